// File: rtl/matrix_fsl_pkg.sv
// Shared constants, state encoding and send-order helpers for the matrix FSL feeder.
package matrix_fsl_pkg;

   localparam int DW        = 32;
   localparam int N         = 4;
   localparam int PIX_BASE  = 16;
   localparam int SND_WORDS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Send word k interleaves matrix[row][col] (even k) with pixel[col] (odd k).
   function automatic logic [1:0] word_row(input logic [5:0] k);
      return k[4:3];
   endfunction

   function automatic logic [1:0] word_col(input logic [5:0] k);
      return k[2:1];
   endfunction

endpackage

// File: rtl/matrix_fsl_feeder_word_sel.sv
// Combinational selection of the outgoing FSL master word from the send counter
// and the operand registers; drives zero once all words have been sent.
module feeder_word_sel #(
   parameter int DW = matrix_fsl_pkg::DW,
   parameter int N  = matrix_fsl_pkg::N
) (
   input  logic [5:0]    snd_cnt,
   input  logic [DW-1:0] mat [N*N],
   input  logic [DW-1:0] pix [N],
   output logic [DW-1:0] word
);
   import matrix_fsl_pkg::*;

   logic [1:0] row;
   logic [1:0] col;

   always_comb begin
      row  = word_row(snd_cnt);
      col  = word_col(snd_cnt);
      word = '0;
      if (snd_cnt < 6'(SND_WORDS)) begin
         if (snd_cnt[0]) begin
            word = pix[col];
         end else begin
            word = mat[{row, col}];
         end
      end
   end

endmodule

// File: rtl/matrix_fsl_feeder.sv
// FSL master-side driver for the matrixmult core: streams a 4x4 matrix and pixel
// vector, collects four result words. Optional watchdog: define FEEDER_TIMEOUT_EN.
module matrix_fsl_feeder #(
   parameter int DW          = matrix_fsl_pkg::DW,
   parameter int N           = matrix_fsl_pkg::N,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic          FSL_Clk,
   input  logic          FSL_Rst_n,
   input  logic          ld_we,
   input  logic [4:0]    ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] res_0,
   output logic [DW-1:0] res_1,
   output logic [DW-1:0] res_2,
   output logic [DW-1:0] res_3,
   output logic          FSL_M_Write,
   output logic [DW-1:0] FSL_M_Data,
   output logic          FSL_M_Control,
   input  logic          FSL_M_Full,
   output logic          FSL_S_Read,
   input  logic [DW-1:0] FSL_S_Data,
   input  logic          FSL_S_Exists,
   input  logic          FSL_S_Control
);
   import matrix_fsl_pkg::*;

   state_e        state_q, state_d;
   logic [5:0]    snd_cnt_q, snd_cnt_d;
   logic [2:0]    rcv_cnt_q, rcv_cnt_d;
   logic [DW-1:0] mat_q [N*N];
   logic [DW-1:0] mat_d [N*N];
   logic [DW-1:0] pix_q [N];
   logic [DW-1:0] pix_d [N];
   logic [DW-1:0] res_q [N];
   logic [DW-1:0] res_d [N];
   logic          err_q, err_d;
   logic          m_write;
   logic          s_read;
   logic          wd_expire;

   // Strobes come straight from registered state so a word moves every cycle.
   always_comb begin
      m_write = (state_q == RUN) && (snd_cnt_q < 6'(SND_WORDS)) && !FSL_M_Full;
      s_read  = (state_q == RUN) && (rcv_cnt_q < 3'(N)) && FSL_S_Exists;
   end

   // Operand writes are blocked only while a transfer is streaming them out.
   always_comb begin
      mat_d = mat_q;
      pix_d = pix_q;
      if (ld_we && (state_q != RUN)) begin
         if (ld_addr < 5'(PIX_BASE)) begin
            mat_d[ld_addr[3:0]] = ld_data;
         end else if (ld_addr < 5'(PIX_BASE + N)) begin
            pix_d[ld_addr[1:0]] = ld_data;
         end
      end
   end

   // Completion is judged on the next counter values so done follows the
   // final handshake by exactly one cycle.
   always_comb begin
      state_d   = state_q;
      snd_cnt_d = snd_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      res_d     = res_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               snd_cnt_d = '0;
               rcv_cnt_d = '0;
            end
         end
         RUN: begin
            if (m_write) begin
               snd_cnt_d = snd_cnt_q + 6'd1;
            end
            if (s_read) begin
               res_d[rcv_cnt_q[1:0]] = FSL_S_Data;
               rcv_cnt_d             = rcv_cnt_q + 3'd1;
            end
            if ((snd_cnt_d == 6'(SND_WORDS)) && (rcv_cnt_d == 3'(N))) begin
               state_d = DONE;
            end else if (wd_expire) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef FEEDER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   // Watchdog only runs once the whole operand stream is out; any read restarts it.
   always_comb begin
      wd_cnt_d  = '0;
      wd_expire = 1'b0;
      if ((state_q == RUN) && (snd_cnt_q == 6'(SND_WORDS)) && !s_read) begin
         if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
            wd_expire = 1'b1;
         end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
         end
      end
   end

   always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
      if (!FSL_Rst_n) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`else
   logic [31:0] unused_cfg;

   assign wd_expire  = 1'b0;
   assign unused_cfg = 32'(TIMEOUT_CYC);
`endif

   always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
      if (!FSL_Rst_n) begin
         state_q   <= IDLE;
         snd_cnt_q <= '0;
         rcv_cnt_q <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < N*N; i++) begin
            mat_q[i] <= '0;
         end
         for (int i = 0; i < N; i++) begin
            pix_q[i] <= '0;
            res_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         snd_cnt_q <= snd_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
         err_q     <= err_d;
         mat_q     <= mat_d;
         pix_q     <= pix_d;
         res_q     <= res_d;
      end
   end

   feeder_word_sel #(
      .DW (DW),
      .N  (N)
   ) u_word_sel (
      .snd_cnt (snd_cnt_q),
      .mat     (mat_q),
      .pix     (pix_q),
      .word    (FSL_M_Data)
   );

   logic unused_ctrl;

   assign unused_ctrl   = FSL_S_Control;
   assign busy          = (state_q == RUN);
   assign done          = (state_q == DONE);
   assign err           = err_q;
   assign res_0         = res_q[0];
   assign res_1         = res_q[1];
   assign res_2         = res_q[2];
   assign res_3         = res_q[3];
   assign FSL_M_Write   = m_write;
   assign FSL_M_Control = 1'b0;
   assign FSL_S_Read    = s_read;

endmodule

// File: tb/tb_matrix_fsl_feeder.sv
// Self-checking bench for matrix_fsl_feeder: randomized operands and link behaviour
// checked against an operand-array / expected-word-queue model of the feeder.
module tb_matrix_fsl_feeder;

   logic        FSL_Clk = 1'b0;
   logic        FSL_Rst_n = 1'b0;
   logic        ld_we = 1'b0;
   logic [4:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        start = 1'b0;
   logic        busy, done, err;
   logic [31:0] res_0, res_1, res_2, res_3;
   logic        FSL_M_Write, FSL_M_Control, FSL_S_Read;
   logic [31:0] FSL_M_Data;
   logic        FSL_M_Full = 1'b0;
   logic [31:0] FSL_S_Data = '0;
   logic        FSL_S_Exists = 1'b0;
   logic        FSL_S_Control = 1'b0;

   int total = 0;
   int bad = 0;

   logic [31:0] m_mat [16];
   logic [31:0] m_pix [4];
   logic [31:0] res_src [4];
   logic [31:0] first_words [4];

   always #5 FSL_Clk = ~FSL_Clk;

   matrix_fsl_feeder dut (
      .FSL_Clk       (FSL_Clk),
      .FSL_Rst_n     (FSL_Rst_n),
      .ld_we         (ld_we),
      .ld_addr       (ld_addr),
      .ld_data       (ld_data),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .res_0         (res_0),
      .res_1         (res_1),
      .res_2         (res_2),
      .res_3         (res_3),
      .FSL_M_Write   (FSL_M_Write),
      .FSL_M_Data    (FSL_M_Data),
      .FSL_M_Control (FSL_M_Control),
      .FSL_M_Full    (FSL_M_Full),
      .FSL_S_Read    (FSL_S_Read),
      .FSL_S_Data    (FSL_S_Data),
      .FSL_S_Exists  (FSL_S_Exists),
      .FSL_S_Control (FSL_S_Control)
   );

   task automatic tick();
      @(posedge FSL_Clk);
      #1;
   endtask

   task automatic load(input logic [4:0] a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_we = 1'b0;
      if (a < 5'd16) m_mat[a[3:0]] = d;
      else if (a < 5'd20) m_pix[a[1:0]] = d;
   endtask

   task automatic load_random();
      for (int i = 0; i < 20; i++) load(5'(i), $urandom);
      load(5'(20 + $urandom_range(0, 11)), $urandom);
      for (int i = 0; i < 4; i++) res_src[i] = $urandom;
   endtask

   // full_mode: 0 never full, 1 stall 3 cycles at word 3, 2 random.
   // ex_mode: 0 one result per completed row, 1 all present from word 8, 2 random.
   task automatic run_xfer(input string name, input int full_mode, input int ex_mode,
                           input bit ld_with_start);
      logic [31:0] exp_w [$];
      logic [31:0] rv [4];
      int n_sent = 0, n_rd = 0, n_done = 0, stall = 0;
      int first_w = -1, last_w = -1, last_hs = -1, done_cyc = -1;
      ld_we = 1'b0;
      if (ld_with_start) begin
         ld_we   = 1'b1;
         ld_addr = 5'd5;
         ld_data = $urandom;
         m_mat[5] = ld_data;
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            exp_w.push_back(m_mat[r*4 + c]);
            exp_w.push_back(m_pix[c]);
         end
      start = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc > 0) begin
            start   = 1'b0;
            ld_we   = busy && ($urandom_range(0, 3) == 0);
            ld_addr = 5'($urandom);
            ld_data = $urandom;
         end
         case (full_mode)
            0:       FSL_M_Full = 1'b0;
            1:       FSL_M_Full = (n_sent == 3) && (stall < 3);
            default: FSL_M_Full = ($urandom_range(0, 2) == 0);
         endcase
         case (ex_mode)
            0:       FSL_S_Exists = (n_rd < 4) && (n_sent >= 8 * (n_rd + 1));
            1:       FSL_S_Exists = (n_sent >= 8);
            default: FSL_S_Exists = ($urandom_range(0, 1) == 1);
         endcase
         FSL_S_Data = (n_rd < 4) ? res_src[n_rd] : $urandom;
         @(negedge FSL_Clk);
         if (busy && n_sent < 32) begin
            total++;
            if (FSL_M_Data !== exp_w[n_sent]) begin
               bad++;
               $display("FAIL %s m_data word %0d: got %h want %h", name, n_sent, FSL_M_Data, exp_w[n_sent]);
            end
         end
         if (FSL_M_Full) stall++;
         if (FSL_M_Write) begin
            if (n_sent < 4) first_words[n_sent] = FSL_M_Data;
            if (first_w < 0) first_w = cyc;
            last_w  = cyc;
            last_hs = cyc;
            n_sent++;
         end
         if (FSL_S_Read) begin
            n_rd++;
            last_hs = cyc;
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL %s busy_at_done: got %b want 0", name, busy);
            end
         end
         tick();
         if (done_cyc >= 0) break;
      end
      ld_we = 1'b0;
      FSL_M_Full = 1'b0;
      FSL_S_Exists = 1'b0;
      total++;
      if (done_cyc < 0) begin
         bad++;
         $display("FAIL %s timeout: got no done want done within 600 cycles", name);
      end
      total++;
      if (n_sent != 32) begin
         bad++;
         $display("FAIL %s write_count: got %0d want 32", name, n_sent);
      end
      total++;
      if (n_rd != 4) begin
         bad++;
         $display("FAIL %s read_count: got %0d want 4", name, n_rd);
      end
      total++;
      if (done_cyc != last_hs + 1) begin
         bad++;
         $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_hs + 1);
      end
      if (full_mode == 0) begin
         total++;
         if (first_w != 1 || last_w - first_w != 31) begin
            bad++;
            $display("FAIL %s write_span: got first %0d last %0d want first 1 last 32", name, first_w, last_w);
         end
      end
      rv[0] = res_0; rv[1] = res_1; rv[2] = res_2; rv[3] = res_3;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rv[i] !== res_src[i]) begin
            bad++;
            $display("FAIL %s res_%0d: got %h want %h", name, i, rv[i], res_src[i]);
         end
      end
      // Idle afterwards with unsolicited slave data present.
      FSL_S_Exists = 1'b1;
      FSL_S_Data   = $urandom;
      @(negedge FSL_Clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || FSL_S_Read !== 1'b0 || err !== 1'b0 || n_done != 1) begin
         bad++;
         $display("FAIL %s after_done: got done %b busy %b read %b err %b pulses %0d want 0 0 0 0 1",
                  name, done, busy, FSL_S_Read, err, n_done);
      end
      tick();
      FSL_S_Exists = 1'b0;
      total++;
      if ({res_0, res_1, res_2, res_3} !== {res_src[0], res_src[1], res_src[2], res_src[3]}) begin
         bad++;
         $display("FAIL %s res_stable: got %h %h %h %h want %h %h %h %h", name, res_0, res_1, res_2, res_3,
                  res_src[0], res_src[1], res_src[2], res_src[3]);
      end
   endtask

   task automatic check_all_zero(input string name);
      total++;
      if ({busy, done, err, FSL_M_Write, FSL_S_Read, FSL_M_Control} !== 6'b0 ||
          FSL_M_Data !== 32'd0 || {res_0, res_1, res_2, res_3} !== 128'd0) begin
         bad++;
         $display("FAIL %s outputs_zero: got busy %b done %b err %b wr %b rd %b data %h res %h %h %h %h want all 0",
                  name, busy, done, err, FSL_M_Write, FSL_S_Read, FSL_M_Data, res_0, res_1, res_2, res_3);
      end
   endtask

   task automatic test_reset();
      FSL_Rst_n = 1'b0;
      FSL_S_Exists = 1'b1;
      #2;
      check_all_zero("reset");
      tick();
      tick();
      FSL_Rst_n = 1'b1;
      FSL_S_Exists = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) m_mat[i] = '0;
      for (int i = 0; i < 4; i++) m_pix[i] = '0;
      check_all_zero("post_reset");
   endtask

   task automatic test_basic_send();
      logic [31:0] row0 [4];
      logic [31:0] pix [4];
      logic [31:0] want [4];
      row0 = '{32'h4124CCCD, 32'h40C80000, 32'h40A9999A, 32'h3C4CCCCD};
      pix  = '{32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7};
      want = '{32'h4124CCCD, 32'hBF07AE14, 32'h40C80000, 32'h4141999A};
      load_random();
      for (int i = 0; i < 4; i++) load(5'(i), row0[i]);
      for (int i = 0; i < 4; i++) load(5'(16 + i), pix[i]);
      res_src = '{32'hC0E08E56, 32'h43BBB7CF, 32'h43B80498, 32'h4082161E};
      run_xfer("basic", 0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (first_words[i] !== want[i]) begin
            bad++;
            $display("FAIL basic first_word_%0d: got %h want %h", i, first_words[i], want[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      load_random();
      run_xfer("backpressure", 1, 0, 1'b0);
   endtask

   task automatic test_early_results();
      load_random();
      run_xfer("early", 0, 1, 1'b0);
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         load_random();
         run_xfer("random", 2, 2, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid_send();
      int n_sent = 0;
      load_random();
      start = 1'b1;
      FSL_S_Exists = 1'b1;
      FSL_S_Data = $urandom;
      for (int cyc = 0; cyc < 100 && n_sent < 10; cyc++) begin
         @(negedge FSL_Clk);
         if (FSL_M_Write) n_sent++;
         tick();
         start = 1'b0;
      end
      start = 1'b0;
      total++;
      if (n_sent != 10) begin
         bad++;
         $display("FAIL midreset reach_word10: got %0d want 10", n_sent);
      end
      FSL_Rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      tick();
      FSL_Rst_n = 1'b1;
      FSL_S_Exists = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) m_mat[i] = '0;
      for (int i = 0; i < 4; i++) m_pix[i] = '0;
      check_all_zero("midreset_release");
      load_random();
      run_xfer("after_reset", 0, 0, 1'b0);
   endtask

`ifdef FEEDER_TIMEOUT_EN
   task automatic test_watchdog();
      int n_sent = 0, last_w = -1, err_cyc = -1, n_done = 0;
      load_random();
      FSL_M_Full = 1'b0;
      FSL_S_Exists = 1'b0;
      start = 1'b1;
      for (int cyc = 0; cyc < 1300; cyc++) begin
         if (cyc > 0) start = 1'b0;
         @(negedge FSL_Clk);
         if (FSL_M_Write) begin
            n_sent++;
            last_w = cyc;
         end
         if (done) n_done++;
         if (err && err_cyc < 0) err_cyc = cyc;
         tick();
         if (err_cyc >= 0) break;
      end
      start = 1'b0;
      total++;
      if (err_cyc < 0 || err_cyc - last_w < 1024 || err_cyc - last_w > 1026) begin
         bad++;
         $display("FAIL watchdog err_timing: got %0d cycles after last write want 1024..1026", err_cyc - last_w);
      end
      total++;
      if (n_sent != 32 || n_done != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL watchdog state: got writes %0d done %0d busy %b want 32 0 0", n_sent, n_done, busy);
      end
      @(negedge FSL_Clk);
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL watchdog err_pulse: got err %b busy %b want 0 0", err, busy);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_basic_send();
      test_backpressure();
      test_early_results();
      test_random();
      test_reset_mid_send();
`ifdef FEEDER_TIMEOUT_EN
      test_watchdog();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
